// File: rtl/reqrsp_rr_mux_pkg.sv
// Shared types and helpers for the round-robin reqrsp multiplexer.
// Default request/response structs stand in for the reqrsp typedef macros.
package reqrsp_rr_mux_pkg;

    localparam int unsigned AddrWidth = 32;
    localparam int unsigned DataWidth = 32;
    localparam int unsigned StrbWidth = DataWidth / 8;

    typedef struct packed {
        logic [AddrWidth-1:0] addr;
        logic                 write;
        logic [DataWidth-1:0] data;
        logic [StrbWidth-1:0] strb;
    } rr_q_chan_t;

    typedef struct packed {
        logic [DataWidth-1:0] data;
        logic                 error;
    } rr_p_chan_t;

    typedef struct packed {
        rr_q_chan_t q;
        logic       q_valid;
        logic       p_ready;
    } rr_req_t;

    typedef struct packed {
        rr_p_chan_t p;
        logic       p_valid;
        logic       q_ready;
    } rr_rsp_t;

    // Index width that stays at least one bit wide for single-entry ranges.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 32'd1) ? $clog2(n) : 32'd1;
    endfunction

endpackage

// File: rtl/reqrsp_rr_mux_fifo.sv
// In-order routing FIFO holding the port index of every granted request
// until its response has been handed back (no fall-through).
module reqrsp_rr_mux_fifo
    import reqrsp_rr_mux_pkg::*;
#(
    parameter int unsigned Width = 1,
    parameter int unsigned Depth = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PtrWidth = idx_width(Depth);
    localparam int unsigned CntWidth = $clog2(Depth + 1);

    typedef logic [PtrWidth-1:0] ptr_t;

    logic [Width-1:0]    mem_q [Depth];
    ptr_t                wr_ptr_q, rd_ptr_q;
    logic [CntWidth-1:0] cnt_q;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(Depth - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop_i)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({push_i, pop_i})
                2'b10:   cnt_q <= cnt_q + CntWidth'(1);
                2'b01:   cnt_q <= cnt_q - CntWidth'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; the count alone defines which
    // entries are valid, so clearing the array would only add reset fan-out.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign full_o  = (cnt_q == CntWidth'(Depth));
    assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/reqrsp_rr_mux.sv
// Round-robin multiplexer sharing one reqrsp master port between NrPorts
// requesters; responses are routed back in order through an index FIFO.
module reqrsp_rr_mux
    import reqrsp_rr_mux_pkg::*;
#(
    parameter int unsigned NrPorts      = 2,
    parameter int unsigned RespDepth    = 4,
    parameter type         reqrsp_req_t = rr_req_t,
    parameter type         reqrsp_rsp_t = rr_rsp_t
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  reqrsp_req_t slv_req_i [NrPorts],
    output reqrsp_rsp_t slv_rsp_o [NrPorts],
    output reqrsp_req_t mst_req_o,
    input  reqrsp_rsp_t mst_rsp_i
);

    localparam int unsigned IdxWidth = idx_width(NrPorts);

    typedef logic [IdxWidth-1:0] idx_t;

    idx_t   rr_q, rr_d, sel_q, sel_d, sel, scan_sel, head;
    logic   lock_q, lock_d;
    logic   fifo_full, fifo_empty, q_hs, p_hs;
    int     scan_idx;

    // Lowest offset from rr_q wins, so iterate from the far end downward.
    always_comb begin
        scan_sel = rr_q;
        scan_idx = 0;
        for (int k = int'(NrPorts) - 1; k >= 0; k--) begin
            scan_idx = int'(rr_q) + k;
            if (scan_idx >= int'(NrPorts)) scan_idx = scan_idx - int'(NrPorts);
            if (slv_req_i[idx_t'(scan_idx)].q_valid) scan_sel = idx_t'(scan_idx);
        end
    end

    assign sel  = lock_q ? sel_q : scan_sel;
    assign q_hs = mst_req_o.q_valid & mst_rsp_i.q_ready;
    assign p_hs = mst_rsp_i.p_valid & mst_req_o.p_ready;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q   <= '0;
            sel_q  <= '0;
            lock_q <= 1'b0;
        end else begin
            rr_q   <= rr_d;
            sel_q  <= sel_d;
            lock_q <= lock_d;
        end
    end

    // NOTE: every variable driven here gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        rr_d   = rr_q;
        sel_d  = sel_q;
        lock_d = lock_q;
        if (q_hs) begin
            rr_d   = (sel == idx_t'(NrPorts - 1)) ? '0 : sel + idx_t'(1);
            lock_d = 1'b0;
        end else if (mst_req_o.q_valid) begin
            lock_d = 1'b1;
            sel_d  = sel;
        end
        if (NrPorts == 1) begin
            rr_d   = '0;
            sel_d  = '0;
            lock_d = 1'b0;
        end
    end

    always_comb begin
        mst_req_o         = '0;
        mst_req_o.q       = slv_req_i[sel].q;
        mst_req_o.q_valid = slv_req_i[sel].q_valid & ~fifo_full;
        mst_req_o.p_ready = slv_req_i[head].p_ready & ~fifo_empty;
        for (int i = 0; i < int'(NrPorts); i++) begin
            slv_rsp_o[i]         = '0;
            slv_rsp_o[i].p       = mst_rsp_i.p;
            slv_rsp_o[i].p_valid = (idx_t'(i) == head) & mst_rsp_i.p_valid & ~fifo_empty;
            slv_rsp_o[i].q_ready = (idx_t'(i) == sel) & mst_rsp_i.q_ready & ~fifo_full;
        end
    end

    reqrsp_rr_mux_fifo #(
        .Width (IdxWidth),
        .Depth (RespDepth)
    ) i_route_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (q_hs),
        .data_i  (sel),
        .pop_i   (p_hs),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    logic [NrPorts-1:0] q_ready_vec, p_valid_vec;

    always_comb begin
        for (int i = 0; i < int'(NrPorts); i++) begin
            q_ready_vec[i] = slv_rsp_o[i].q_ready;
            p_valid_vec[i] = slv_rsp_o[i].p_valid;
        end
    end

    a_lock_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        lock_q |-> (slv_req_i[sel_q].q_valid && mst_req_o.q == $past(mst_req_o.q)));
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(q_hs && fifo_full));
    a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(mst_rsp_i.p_valid && fifo_empty));
    a_onehot_q_ready: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(q_ready_vec));
    a_onehot_p_valid: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(p_valid_vec));

endmodule

// File: tb/tb_reqrsp_rr_mux.sv
// Directed bench for reqrsp_rr_mux with three ports and a two-deep routing FIFO.
module tb_reqrsp_rr_mux;
    import reqrsp_rr_mux_pkg::*;

    localparam int NrPorts   = 3;
    localparam int RespDepth = 2;

    logic    clk = 1'b0;
    logic    rst_n;
    rr_req_t slv_req [NrPorts];
    rr_rsp_t slv_rsp [NrPorts];
    rr_req_t mst_req;
    rr_rsp_t mst_rsp;
    logic [2:0] qr_vec, pv_vec;
    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    reqrsp_rr_mux #(
        .NrPorts      (NrPorts),
        .RespDepth    (RespDepth),
        .reqrsp_req_t (rr_req_t),
        .reqrsp_rsp_t (rr_rsp_t)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .slv_req_i (slv_req),
        .slv_rsp_o (slv_rsp),
        .mst_req_o (mst_req),
        .mst_rsp_i (mst_rsp)
    );

    assign qr_vec = {slv_rsp[2].q_ready, slv_rsp[1].q_ready, slv_rsp[0].q_ready};
    assign pv_vec = {slv_rsp[2].p_valid, slv_rsp[1].p_valid, slv_rsp[0].p_valid};

    function automatic logic [31:0] addr_of(input int port);
        return 32'h1000 + 32'(port);
    endfunction

    task automatic drive_idle();
        for (int i = 0; i < NrPorts; i++) begin
            slv_req[i]         = '0;
            slv_req[i].p_ready = 1'b1;
        end
        mst_rsp         = '0;
        mst_rsp.q_ready = 1'b1;
    endtask

    task automatic set_q(input int port, input logic valid);
        slv_req[port].q_valid = valid;
        slv_req[port].q.addr  = addr_of(port);
        slv_req[port].q.data  = 32'hA000 + 32'(port);
    endtask

    task automatic respond(input logic valid, input int port);
        mst_rsp.p_valid = valid;
        mst_rsp.p.data  = 32'hD000 + 32'(port);
        mst_rsp.p.error = 1'b0;
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are read 1 unit later.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_idle();
        #2;
        vec_cnt++;
        if (pv_vec !== 3'b000 || mst_req.p_ready !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_rsp_outputs: p_valid=%b p_ready=%b, need 000/0", pv_vec, mst_req.p_ready);
        end
        vec_cnt++;
        if (qr_vec !== 3'b001 || mst_req.q_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_q_path: q_ready=%b q_valid=%b, need 001/0", qr_vec, mst_req.q_valid);
        end
        repeat (2) next_cycle();
        rst_n = 1'b1;
        #1;
        vec_cnt++;
        if (qr_vec !== 3'b001 || pv_vec !== 3'b000) begin
            err_cnt++;
            $display("FAIL reset_release: q_ready=%b p_valid=%b, need 001/000", qr_vec, pv_vec);
        end
    endtask

    // All ports request every cycle; each response carries the port granted one cycle earlier.
    task automatic test_contention();
        int exp_grant [4] = '{0, 1, 2, 0};
        for (int c = 0; c < 5; c++) begin
            next_cycle();
            for (int p = 0; p < NrPorts; p++) set_q(p, c < 4);
            respond(c > 0, (c > 0) ? exp_grant[c-1] : 0);
            #1;
            if (c < 4) begin
                vec_cnt++;
                if (mst_req.q_valid !== 1'b1 || mst_req.q.addr !== addr_of(exp_grant[c])
                    || qr_vec !== 3'(1 << exp_grant[c])) begin
                    err_cnt++;
                    $display("FAIL contention_grant[%0d]: q_valid=%b addr=%h q_ready=%b, need 1 addr=%h q_ready=%b",
                             c, mst_req.q_valid, mst_req.q.addr, qr_vec, addr_of(exp_grant[c]), 3'(1 << exp_grant[c]));
                end
            end else begin
                vec_cnt++;
                if (mst_req.q_valid !== 1'b0) begin
                    err_cnt++;
                    $display("FAIL contention_idle: q_valid=%b, need 0", mst_req.q_valid);
                end
            end
            if (c > 0) begin
                vec_cnt++;
                if (pv_vec !== 3'(1 << exp_grant[c-1]) || mst_req.p_ready !== 1'b1
                    || slv_rsp[exp_grant[c-1]].p.data !== 32'hD000 + 32'(exp_grant[c-1])) begin
                    err_cnt++;
                    $display("FAIL contention_rsp[%0d]: p_valid=%b p_ready=%b data=%h, need p_valid=%b p_ready=1 data=%h",
                             c, pv_vec, mst_req.p_ready, slv_rsp[exp_grant[c-1]].p.data,
                             3'(1 << exp_grant[c-1]), 32'hD000 + 32'(exp_grant[c-1]));
                end
            end
        end
    endtask

    // One request and one response per cycle must never stall a two-deep FIFO.
    task automatic test_push_pop();
        for (int c = 0; c < 6; c++) begin
            next_cycle();
            set_q(0, c < 5);
            set_q(1, 1'b0);
            set_q(2, 1'b0);
            respond(c > 0, 0);
            #1;
            if (c < 5) begin
                vec_cnt++;
                if (mst_req.q_valid !== 1'b1 || qr_vec !== 3'b001) begin
                    err_cnt++;
                    $display("FAIL push_pop_req[%0d]: q_valid=%b q_ready=%b, need 1/001", c, mst_req.q_valid, qr_vec);
                end
            end
            if (c > 0) begin
                vec_cnt++;
                if (pv_vec !== 3'b001 || mst_req.p_ready !== 1'b1) begin
                    err_cnt++;
                    $display("FAIL push_pop_rsp[%0d]: p_valid=%b p_ready=%b, need 001/1", c, pv_vec, mst_req.p_ready);
                end
            end
        end
    endtask

    // Pointer sits at 1: port 1 is stalled for 3 cycles while port 0 also waits.
    task automatic test_lock();
        next_cycle();
        set_q(0, 1'b1);
        set_q(1, 1'b1);
        set_q(2, 1'b0);
        respond(1'b0, 0);
        mst_rsp.q_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) next_cycle();
            if (c == 3) mst_rsp.q_ready = 1'b1;
            #1;
            vec_cnt++;
            if (mst_req.q_valid !== 1'b1 || mst_req.q.addr !== addr_of(1)
                || qr_vec !== ((c == 3) ? 3'b010 : 3'b000)) begin
                err_cnt++;
                $display("FAIL lock_hold[%0d]: q_valid=%b addr=%h q_ready=%b, need 1 addr=%h q_ready=%b",
                         c, mst_req.q_valid, mst_req.q.addr, qr_vec, addr_of(1), (c == 3) ? 3'b010 : 3'b000);
            end
        end
        next_cycle();
        set_q(1, 1'b0);
        #1;
        vec_cnt++;
        if (mst_req.q.addr !== addr_of(0) || qr_vec !== 3'b001) begin
            err_cnt++;
            $display("FAIL lock_next_grant: addr=%h q_ready=%b, need addr=%h q_ready=001", mst_req.q.addr, qr_vec, addr_of(0));
        end
    endtask

    // FIFO now holds {1, 0}: a third request must wait until a pop has been registered.
    task automatic test_full();
        next_cycle();
        set_q(0, 1'b0);
        set_q(2, 1'b1);
        #1;
        vec_cnt++;
        if (mst_req.q_valid !== 1'b0 || qr_vec !== 3'b000) begin
            err_cnt++;
            $display("FAIL full_block: q_valid=%b q_ready=%b, need 0/000", mst_req.q_valid, qr_vec);
        end
        next_cycle();
        respond(1'b1, 1);
        #1;
        vec_cnt++;
        if (mst_req.q_valid !== 1'b0 || qr_vec !== 3'b000 || pv_vec !== 3'b010 || mst_req.p_ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL full_pop_cycle: q_valid=%b q_ready=%b p_valid=%b p_ready=%b, need 0/000/010/1",
                     mst_req.q_valid, qr_vec, pv_vec, mst_req.p_ready);
        end
        next_cycle();
        respond(1'b0, 0);
        #1;
        vec_cnt++;
        if (mst_req.q_valid !== 1'b1 || mst_req.q.addr !== addr_of(2) || qr_vec !== 3'b100) begin
            err_cnt++;
            $display("FAIL full_release: q_valid=%b addr=%h q_ready=%b, need 1 addr=%h q_ready=100",
                     mst_req.q_valid, mst_req.q.addr, qr_vec, addr_of(2));
        end
    endtask

    // FIFO holds {0, 2}: drain port 0, then hold port 2 off for 4 cycles.
    task automatic test_backpressure();
        next_cycle();
        set_q(2, 1'b0);
        respond(1'b1, 0);
        #1;
        vec_cnt++;
        if (pv_vec !== 3'b001 || mst_req.p_ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL bp_first_pop: p_valid=%b p_ready=%b, need 001/1", pv_vec, mst_req.p_ready);
        end
        for (int c = 0; c < 5; c++) begin
            next_cycle();
            respond(1'b1, 2);
            slv_req[2].p_ready = (c == 4);
            #1;
            vec_cnt++;
            if (pv_vec !== 3'b100 || mst_req.p_ready !== (c == 4)) begin
                err_cnt++;
                $display("FAIL bp_hold[%0d]: p_valid=%b p_ready=%b, need 100/%0d", c, pv_vec, mst_req.p_ready, c == 4);
            end
        end
        next_cycle();
        respond(1'b0, 0);
        #1;
        vec_cnt++;
        if (mst_req.p_ready !== 1'b0 || pv_vec !== 3'b000) begin
            err_cnt++;
            $display("FAIL bp_drained: p_ready=%b p_valid=%b, need 0/000", mst_req.p_ready, pv_vec);
        end
    endtask

    // Fill the FIFO, reset, then the lowest valid port must win with room to push.
    task automatic test_reset_mid();
        next_cycle();
        set_q(0, 1'b1);
        #1;
        vec_cnt++;
        if (mst_req.q.addr !== addr_of(0) || qr_vec !== 3'b001) begin
            err_cnt++;
            $display("FAIL rst_mid_grant0: addr=%h q_ready=%b, need addr=%h q_ready=001", mst_req.q.addr, qr_vec, addr_of(0));
        end
        next_cycle();
        set_q(0, 1'b0);
        set_q(1, 1'b1);
        #1;
        vec_cnt++;
        if (mst_req.q.addr !== addr_of(1) || qr_vec !== 3'b010) begin
            err_cnt++;
            $display("FAIL rst_mid_grant1: addr=%h q_ready=%b, need addr=%h q_ready=010", mst_req.q.addr, qr_vec, addr_of(1));
        end
        next_cycle();
        set_q(1, 1'b0);
        rst_n = 1'b0;
        #1;
        vec_cnt++;
        if (pv_vec !== 3'b000 || mst_req.p_ready !== 1'b0) begin
            err_cnt++;
            $display("FAIL rst_mid_outputs: p_valid=%b p_ready=%b, need 000/0", pv_vec, mst_req.p_ready);
        end
        repeat (2) next_cycle();
        rst_n = 1'b1;
        set_q(1, 1'b1);
        set_q(2, 1'b1);
        #1;
        vec_cnt++;
        if (mst_req.q_valid !== 1'b1 || mst_req.q.addr !== addr_of(1) || qr_vec !== 3'b010) begin
            err_cnt++;
            $display("FAIL rst_mid_first_grant: q_valid=%b addr=%h q_ready=%b, need 1 addr=%h q_ready=010",
                     mst_req.q_valid, mst_req.q.addr, qr_vec, addr_of(1));
        end
        next_cycle();
        drive_idle();
    endtask

    initial begin
        test_reset();
        test_contention();
        test_push_pop();
        test_lock();
        test_full();
        test_backpressure();
        test_reset_mid();
        repeat (2) next_cycle();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, need completion", $time);
        $fatal(1);
    end

endmodule
